// File: rtl/note_feeder_if.sv
// Signal bundle between note_feeder and its environment: run control, chart ROM port,
// player hit events, and the scorer feedback loop.
interface note_feeder_if #(
    parameter int unsigned CLK_W  = 21,
    parameter int unsigned OCT_W  = 2,
    parameter int unsigned NOTE_W = 3,
    parameter int unsigned LEN_W  = 3,
    parameter int unsigned ADDR_W = 8
);
    localparam int unsigned ROM_W   = 1 + CLK_W + OCT_W + NOTE_W + LEN_W;
    localparam int unsigned SCORE_W = 21;

    // run control and time base
    logic                 start;
    logic                 abort;
    logic [CLK_W-1:0]     song_time;

    // chart ROM port
    logic                 rom_rd;
    logic [ADDR_W-1:0]    rom_addr;
    logic [ROM_W-1:0]     rom_data;

    // player events
    logic                 hit_valid;
    logic [OCT_W-1:0]     hit_octave;
    logic [NOTE_W-1:0]    hit_note;
    logic [LEN_W-1:0]     hit_length;

    // note pair presented to the scorer
    logic [CLK_W-1:0]     goal_time;
    logic [OCT_W-1:0]     goal_octave;
    logic [NOTE_W-1:0]    goal_note;
    logic [LEN_W-1:0]     goal_length;
    logic [CLK_W-1:0]     play_time;
    logic [OCT_W-1:0]     play_octave;
    logic [NOTE_W-1:0]    play_note;
    logic [LEN_W-1:0]     play_length;
    logic                 judge_valid;
    logic                 judge_miss;

    // scorer results and running state fed back to it
    logic [SCORE_W-1:0]   base_score_in;
    logic [SCORE_W-1:0]   combo_in;
    logic [SCORE_W-1:0]   last_combo;
    logic [SCORE_W-1:0]   now_cnt;
    logic [SCORE_W-1:0]   last_base_score;

    // status
    logic                 busy;
    logic                 done;

    modport slave (
        input  start, abort, song_time, rom_data,
        input  hit_valid, hit_octave, hit_note, hit_length,
        input  base_score_in, combo_in,
        output rom_rd, rom_addr,
        output goal_time, goal_octave, goal_note, goal_length,
        output play_time, play_octave, play_note, play_length,
        output judge_valid, judge_miss,
        output last_combo, now_cnt, last_base_score,
        output busy, done
    );

    modport master (
        output start, abort, song_time, rom_data,
        output hit_valid, hit_octave, hit_note, hit_length,
        output base_score_in, combo_in,
        input  rom_rd, rom_addr,
        input  goal_time, goal_octave, goal_note, goal_length,
        input  play_time, play_octave, play_note, play_length,
        input  judge_valid, judge_miss,
        input  last_combo, now_cnt, last_base_score,
        input  busy, done
    );
endinterface

// File: rtl/note_feeder.sv
// Rhythm-game chart sequencer: walks a chart ROM in order, pairs each note with the
// player's hit (or a late miss), presents the pair to the scorer and accumulates its results.
module note_feeder #(
    parameter int unsigned CLK_W    = 21,
    parameter int unsigned OCT_W    = 2,
    parameter int unsigned NOTE_W   = 3,
    parameter int unsigned LEN_W    = 3,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned MISS_WIN = 188
) (
    input  logic         clk,
    input  logic         rst_n,
    note_feeder_if.slave bus
);
    localparam int unsigned ROM_W    = 1 + CLK_W + OCT_W + NOTE_W + LEN_W;
    localparam int unsigned SCORE_W  = 21;
    localparam int unsigned NOTE_LSB = LEN_W;
    localparam int unsigned OCT_LSB  = LEN_W + NOTE_W;
    localparam int unsigned TIME_LSB = LEN_W + NOTE_W + OCT_W;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [ADDR_W-1:0]  ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ARMED,
        S_JUDGE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // datapath enables decoded by the FSM
    logic w_clear;
    logic w_goal_ld;
    logic w_hit_ld;
    logic w_miss_ld;
    logic w_commit;
    logic w_addr_inc;
    logic w_busy_nxt;

    // chart entry fields
    logic                w_end_flag;
    logic [CLK_W-1:0]    w_rom_time;
    logic [OCT_W-1:0]    w_rom_octave;
    logic [NOTE_W-1:0]   w_rom_note;
    logic [LEN_W-1:0]    w_rom_length;
    logic                w_late;
    logic [SCORE_W:0]    w_score_sum;
    logic [SCORE_W-1:0]  w_score_nxt;
    logic [SCORE_W-1:0]  w_cnt_nxt;

    logic                r_rom_rd;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [CLK_W-1:0]    r_goal_time;
    logic [OCT_W-1:0]    r_goal_octave;
    logic [NOTE_W-1:0]   r_goal_note;
    logic [LEN_W-1:0]    r_goal_length;
    logic [CLK_W-1:0]    r_play_time;
    logic [OCT_W-1:0]    r_play_octave;
    logic [NOTE_W-1:0]   r_play_note;
    logic [LEN_W-1:0]    r_play_length;
    logic                r_judge_valid;
    logic                r_judge_miss;
    logic [SCORE_W-1:0]  r_last_combo;
    logic [SCORE_W-1:0]  r_now_cnt;
    logic [SCORE_W-1:0]  r_last_base_score;
    logic                r_busy;
    logic                r_done;

    assign w_end_flag   = bus.rom_data[ROM_W-1];
    assign w_rom_time   = bus.rom_data[TIME_LSB +: CLK_W];
    assign w_rom_octave = bus.rom_data[OCT_LSB +: OCT_W];
    assign w_rom_note   = bus.rom_data[NOTE_LSB +: NOTE_W];
    assign w_rom_length = bus.rom_data[LEN_W-1:0];

    // One extra bit keeps goal_time + MISS_WIN from wrapping near the top of song time.
    assign w_late = {1'b0, bus.song_time} >
                    ({1'b0, r_goal_time} + (CLK_W+1)'(MISS_WIN));

    assign w_score_sum = {1'b0, r_last_base_score} + {1'b0, bus.base_score_in};
    assign w_score_nxt = w_score_sum[SCORE_W] ? SCORE_MAX : w_score_sum[SCORE_W-1:0];
    assign w_cnt_nxt   = (r_now_cnt == SCORE_MAX) ? SCORE_MAX : r_now_cnt + SCORE_W'(1);

    assign w_busy_nxt = (w_state_nxt inside {S_FETCH, S_WAIT, S_ARMED, S_JUDGE});

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state and datapath enables
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_goal_ld   = 1'b0;
        w_hit_ld    = 1'b0;
        w_miss_ld   = 1'b0;
        w_commit    = 1'b0;
        w_addr_inc  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = bus.abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_goal_ld   = 1'b1;
                    w_state_nxt = w_end_flag ? S_DONE : S_ARMED;
                end
            end
            S_ARMED: begin
                // a hit takes priority over an expiry in the same cycle
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.hit_valid) begin
                    w_hit_ld    = 1'b1;
                    w_state_nxt = S_JUDGE;
                end else if (w_late) begin
                    w_miss_ld   = 1'b1;
                    w_state_nxt = S_JUDGE;
                end
            end
            S_JUDGE: begin
                w_commit = 1'b1;
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_rom_addr == ADDR_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_addr_inc  = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes and status follow the state being entered so they coincide with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_rd      <= 1'b0;
            r_judge_valid <= 1'b0;
            r_judge_miss  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_rom_rd      <= (w_state_nxt == S_FETCH);
            r_judge_valid <= (w_state_nxt == S_JUDGE);
            r_judge_miss  <= w_miss_ld;
            r_busy        <= w_busy_nxt;
            r_done        <= (w_state_nxt == S_DONE);
        end
    end

    // chart address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr <= '0;
        end else if (w_clear) begin
            r_rom_addr <= '0;
        end else if (w_addr_inc) begin
            r_rom_addr <= r_rom_addr + ADDR_W'(1);
        end
    end

    // goal note latched from the chart entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_goal_time   <= '0;
            r_goal_octave <= '0;
            r_goal_note   <= '0;
            r_goal_length <= '0;
        end else if (w_goal_ld) begin
            r_goal_time   <= w_rom_time;
            r_goal_octave <= w_rom_octave;
            r_goal_note   <= w_rom_note;
            r_goal_length <= w_rom_length;
        end
    end

    // Played note: the player's hit, or for a miss an inverted goal note so it never matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_play_time   <= '0;
            r_play_octave <= '0;
            r_play_note   <= '0;
            r_play_length <= '0;
        end else if (w_hit_ld) begin
            r_play_time   <= bus.song_time;
            r_play_octave <= bus.hit_octave;
            r_play_note   <= bus.hit_note;
            r_play_length <= bus.hit_length;
        end else if (w_miss_ld) begin
            r_play_time   <= bus.song_time;
            r_play_octave <= r_goal_octave;
            r_play_note   <= ~r_goal_note;
            r_play_length <= r_goal_length;
        end
    end

    // running scorer state, committed at the end of each judgement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_combo      <= '0;
            r_now_cnt         <= '0;
            r_last_base_score <= '0;
        end else if (w_clear) begin
            r_last_combo      <= '0;
            r_now_cnt         <= '0;
            r_last_base_score <= '0;
        end else if (w_commit) begin
            r_last_combo      <= r_judge_miss ? '0 : bus.combo_in;
            r_now_cnt         <= w_cnt_nxt;
            r_last_base_score <= w_score_nxt;
        end
    end

    assign bus.rom_rd          = r_rom_rd;
    assign bus.rom_addr        = r_rom_addr;
    assign bus.goal_time       = r_goal_time;
    assign bus.goal_octave     = r_goal_octave;
    assign bus.goal_note       = r_goal_note;
    assign bus.goal_length     = r_goal_length;
    assign bus.play_time       = r_play_time;
    assign bus.play_octave     = r_play_octave;
    assign bus.play_note       = r_play_note;
    assign bus.play_length     = r_play_length;
    assign bus.judge_valid     = r_judge_valid;
    assign bus.judge_miss      = r_judge_miss;
    assign bus.last_combo      = r_last_combo;
    assign bus.now_cnt         = r_now_cnt;
    assign bus.last_base_score = r_last_base_score;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;

endmodule

// File: tb/tb_note_feeder.sv
// Self-checking bench for note_feeder: single-note vector table, hand-written corner
// sequences, and randomized charts checked against a note-level reference model.
module tb_note_feeder;
    localparam int unsigned CLK_W    = 21;
    localparam int unsigned OCT_W    = 2;
    localparam int unsigned NOTE_W   = 3;
    localparam int unsigned LEN_W    = 3;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned MISS_WIN = 188;
    localparam int unsigned ROM_W    = 1 + CLK_W + OCT_W + NOTE_W + LEN_W;
    localparam int          DEPTH    = 1 << ADDR_W;
    localparam longint      SMAX     = 2097151;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    note_feeder_if #(.CLK_W(CLK_W), .OCT_W(OCT_W), .NOTE_W(NOTE_W), .LEN_W(LEN_W),
                     .ADDR_W(ADDR_W)) bus ();

    note_feeder #(.CLK_W(CLK_W), .OCT_W(OCT_W), .NOTE_W(NOTE_W), .LEN_W(LEN_W),
                  .ADDR_W(ADDR_W), .MISS_WIN(MISS_WIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // chart ROM: one-cycle read latency
    logic [ROM_W-1:0] rom [DEPTH];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bus.rom_data <= '0;
        else if (bus.rom_rd) bus.rom_data <= rom[bus.rom_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    // reference-model state for the randomized run
    int gt [DEPTH];
    int go [DEPTH];
    int gn [DEPTH];
    int gl [DEPTH];
    bit p_hit;
    int e_pt, e_po, e_pn, e_pl;
    int cur_base, cur_combo;

    typedef struct {
        bit hit;  int st;  int hnote;  int base;  int combo;
        bit e_miss;  int e_ptime;  int e_pnote;  int e_lbs;  int e_combo;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [ROM_W-1:0] mk(input int e, input int t, input int o,
                                            input int n, input int l);
        mk = {1'(e), CLK_W'(t), OCT_W'(o), NOTE_W'(n), LEN_W'(l)};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_judge(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (bus.judge_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            step();
            if (bus.done) ok = 1'b1;
        end
    endtask

    task automatic count_judges(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.judge_valid) cnt++;
        end
    endtask

    task automatic load_single();
        rom[0] = mk(0, 100, 1, 3, 2);
        rom[1] = mk(1, 0, 0, 0, 0);
    endtask

    task automatic load_pair();
        rom[0] = mk(0, 100, 1, 3, 2);
        rom[1] = mk(0, 200, 0, 5, 1);
        rom[2] = mk(1, 0, 0, 0, 0);
    endtask

    task automatic set_scores(input int base, input int combo);
        bus.base_score_in = 21'(base);
        bus.combo_in      = 21'(combo);
    endtask

    // Chooses the player's behaviour for note k and derives the expected judgement.
    task automatic plan_note(input int k, input bit big);
        p_hit = ($urandom_range(0, 1) == 1);
        if (p_hit) begin
            e_pt = int'($urandom_range(0, 1 << 20));
            e_po = int'($urandom_range(0, 3));
            e_pn = int'($urandom_range(0, 7));
            e_pl = int'($urandom_range(0, 7));
            bus.hit_octave = OCT_W'(e_po);
            bus.hit_note   = NOTE_W'(e_pn);
            bus.hit_length = LEN_W'(e_pl);
        end else begin
            e_pt = gt[k] + int'(MISS_WIN) + 1 + int'($urandom_range(0, 40));
            e_pn = 7 - gn[k];
        end
        bus.hit_valid = p_hit;
        bus.song_time = CLK_W'(e_pt);
        cur_base  = big ? int'($urandom_range(0, 2097151)) : int'($urandom_range(0, 5000));
        cur_combo = int'($urandom_range(0, 2097151));
        set_scores(cur_base, cur_combo);
    endtask

    initial begin
        bit ok;
        int cnt;
        longint m_lbs, m_cnt, m_combo;

        bus.start = 1'b0;  bus.abort = 1'b0;  bus.song_time = '0;
        bus.hit_valid = 1'b0;  bus.hit_octave = '0;  bus.hit_note = '0;  bus.hit_length = '0;
        set_scores(0, 0);
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;

        vecs[0] = '{1, 105, 3, 1000,    7,  0, 105, 3, 1000,    7};
        vecs[1] = '{0, 289, 0, 50,      9,  1, 289, 4, 50,      0};
        vecs[2] = '{1, 289, 3, 20,      1,  0, 289, 3, 20,      1};
        vecs[3] = '{1, 288, 6, 2000000, 5,  0, 288, 6, 2000000, 5};
        vecs[4] = '{0, 300, 0, 0,       3,  1, 300, 4, 0,       0};
        vecs[5] = '{1, 0,   0, 2097151, 12, 0, 0,   0, 2097151, 12};

        // reset state
        step();
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rom_rd", bus.rom_rd, 0);
        chk("rst_judge_valid", bus.judge_valid, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_now_cnt", bus.now_cnt, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", bus.busy, 0);

        // single-note vector table
        for (int k = 0; k < 6; k++) begin
            load_single();
            bus.hit_valid  = vecs[k].hit;
            bus.hit_note   = NOTE_W'(vecs[k].hnote);
            bus.hit_octave = 2'd2;
            bus.hit_length = 3'd5;
            bus.song_time  = CLK_W'(vecs[k].st);
            set_scores(vecs[k].base, vecs[k].combo);
            pulse_start();
            wait_judge(ok);
            chk("vec_judge_seen", ok, 1);
            if (ok) begin
                chk("vec_miss", bus.judge_miss, vecs[k].e_miss);
                chk("vec_play_time", bus.play_time, vecs[k].e_ptime);
                chk("vec_play_note", bus.play_note, vecs[k].e_pnote);
                chk("vec_goal_time", bus.goal_time, 100);
                chk("vec_goal_note", bus.goal_note, 3);
                if (vecs[k].hit) chk("vec_play_octave", bus.play_octave, 2);
            end
            step();
            chk("vec_last_base_score", bus.last_base_score, vecs[k].e_lbs);
            chk("vec_last_combo", bus.last_combo, vecs[k].e_combo);
            chk("vec_now_cnt", bus.now_cnt, 1);
            wait_done(ok);
            chk("vec_done", ok, 1);
            chk("vec_busy_at_done", bus.busy, 0);
            bus.hit_valid = 1'b0;
        end

        // miss window boundary: no judgement while song_time sits at goal+MISS_WIN
        load_single();
        bus.song_time = CLK_W'(288);
        set_scores(10, 10);
        pulse_start();
        count_judges(8, cnt);
        chk("bnd_no_judge_at_288", cnt, 0);
        chk("bnd_busy_armed", bus.busy, 1);
        bus.song_time = CLK_W'(289);
        wait_judge(ok);
        chk("bnd_judge_seen", ok, 1);
        chk("bnd_miss", bus.judge_miss, 1);
        chk("bnd_play_time", bus.play_time, 289);
        chk("bnd_play_note", bus.play_note, 4);
        step();
        chk("bnd_combo", bus.last_combo, 0);
        chk("bnd_now_cnt", bus.now_cnt, 1);
        wait_done(ok);
        chk("bnd_done", ok, 1);

        // base score saturation across two notes
        load_pair();
        bus.hit_valid = 1'b1;
        bus.hit_note  = 3'd3;
        bus.song_time = CLK_W'(150);
        set_scores(2097151 - 9, 4);
        pulse_start();
        wait_judge(ok);
        step();
        chk("sat_first_score", bus.last_base_score, 2097151 - 9);
        set_scores(100, 4);
        wait_judge(ok);
        chk("sat_second_judge_seen", ok, 1);
        step();
        chk("sat_score", bus.last_base_score, SMAX);
        chk("sat_now_cnt", bus.now_cnt, 2);
        wait_done(ok);
        chk("sat_done", ok, 1);

        // abort during a judgement still commits the result
        set_scores(5, 6);
        pulse_start();
        wait_judge(ok);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abj_now_cnt", bus.now_cnt, 1);
        chk("abj_score", bus.last_base_score, 5);
        chk("abj_busy", bus.busy, 0);
        chk("abj_done", bus.done, 0);
        count_judges(6, cnt);
        chk("abj_no_judge", cnt, 0);

        // abort while armed, then a restart from address 0 with cleared counters
        set_scores(7, 8);
        pulse_start();
        wait_judge(ok);
        step();
        bus.hit_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("aba_busy", bus.busy, 0);
        chk("aba_done", bus.done, 0);
        chk("aba_now_cnt_kept", bus.now_cnt, 1);
        chk("aba_score_kept", bus.last_base_score, 7);
        count_judges(6, cnt);
        chk("aba_no_judge", cnt, 0);
        pulse_start();
        chk("aba_restart_rd", bus.rom_rd, 1);
        chk("aba_restart_addr", bus.rom_addr, 0);
        chk("aba_restart_cnt", bus.now_cnt, 0);
        chk("aba_restart_score", bus.last_base_score, 0);
        bus.hit_valid = 1'b1;
        wait_done(ok);
        chk("aba_restart_done", ok, 1);

        // reset while judging: outputs clear at once and nothing commits
        load_single();
        bus.song_time = CLK_W'(105);
        set_scores(77, 3);
        pulse_start();
        wait_judge(ok);
        rst_n = 1'b0;
        #1;
        chk("rsj_judge_valid", bus.judge_valid, 0);
        chk("rsj_busy", bus.busy, 0);
        chk("rsj_play_time", bus.play_time, 0);
        chk("rsj_goal_time", bus.goal_time, 0);
        chk("rsj_score", bus.last_base_score, 0);
        step();
        step();
        rst_n = 1'b1;
        count_judges(10, cnt);
        chk("rsj_no_judge_after", cnt, 0);
        chk("rsj_now_cnt", bus.now_cnt, 0);
        chk("rsj_busy_after", bus.busy, 0);

        // randomized charts against the note-level model
        for (int r = 0; r < 6; r++) begin
            int n;
            n = (r == 5) ? DEPTH : int'($urandom_range(1, 6));
            for (int i = 0; i < DEPTH; i++) begin
                gt[i] = int'($urandom_range(0, 1 << 20));
                go[i] = int'($urandom_range(0, 3));
                gn[i] = int'($urandom_range(0, 7));
                gl[i] = int'($urandom_range(0, 7));
                rom[i] = mk((i >= n) ? 1 : 0, gt[i], go[i], gn[i], gl[i]);
            end
            m_lbs = 0;
            m_cnt = 0;
            m_combo = 0;
            plan_note(0, r >= 3);
            pulse_start();
            for (int k = 0; k < n; k++) begin
                wait_judge(ok);
                chk("rnd_judge_seen", ok, 1);
                if (!ok) break;
                chk("rnd_goal_time", bus.goal_time, gt[k]);
                chk("rnd_goal_note", bus.goal_note, gn[k]);
                chk("rnd_miss", bus.judge_miss, p_hit ? 0 : 1);
                chk("rnd_play_time", bus.play_time, e_pt);
                chk("rnd_play_note", bus.play_note, e_pn);
                if (p_hit) begin
                    chk("rnd_play_octave", bus.play_octave, e_po);
                    chk("rnd_play_length", bus.play_length, e_pl);
                end
                m_lbs   = (m_lbs + cur_base > SMAX) ? SMAX : m_lbs + cur_base;
                m_cnt   = (m_cnt + 1 > SMAX) ? SMAX : m_cnt + 1;
                m_combo = p_hit ? longint'(cur_combo) : 0;
                step();
                chk("rnd_score", bus.last_base_score, m_lbs);
                chk("rnd_now_cnt", bus.now_cnt, m_cnt);
                chk("rnd_combo", bus.last_combo, m_combo);
                if (k + 1 < n) plan_note(k + 1, r >= 3);
            end
            wait_done(ok);
            chk("rnd_done", ok, 1);
            count_judges(4, cnt);
            chk("rnd_no_extra_judge", cnt, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/note_feeder.md
NOTE_FEEDER -- requirements
Module: note_feeder

Interface
REQ-001 SHALL have parameter CLK_W, default 21: width of song time and chart time fields.
REQ-002 SHALL have parameter OCT_W, default 2: octave field width.
REQ-003 SHALL have parameter NOTE_W, default 3: note field width.
REQ-004 SHALL have parameter LEN_W, default 3: length field width.
REQ-005 SHALL have parameter ADDR_W, default 8: chart ROM address width.
REQ-006 SHALL have parameter MISS_WIN, default 188: late-miss window in song-time ticks.
REQ-007 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have the following further ports:
- start  in  1  one-cycle pulse that begins chart playback.
- abort  in  1  one-cycle pulse that stops playback.
- song_time  in  CLK_W  free-running game time.
- rom_rd  out  1  chart read strobe.
- rom_addr  out  ADDR_W  chart entry index.
- rom_data  in  1+CLK_W+OCT_W+NOTE_W+LEN_W  {end_flag,time,octave,note,length}, valid exactly 1 cycle after rom_rd.
- hit_valid  in  1  player event strobe.
- hit_octave, hit_note, hit_length  in  OCT_W/NOTE_W/LEN_W  player event fields.
- goal_time, goal_octave, goal_note, goal_length  out  per field  goal note presented to scorer.
- play_time, play_octave, play_note, play_length  out  per field  played note presented to scorer.
- judge_valid  out  1  one-cycle pulse: scorer inputs are final this cycle.
- judge_miss  out  1  qualifies judge_valid; 1 means the note was missed.
- base_score_in, combo_in  in  21 each  scorer results.
- last_combo, now_cnt, last_base_score  out  21 each  running state fed back to the scorer.
- busy, done  out  1 each  status.

Function
REQ-009 SHALL implement states IDLE, FETCH, WAIT, ARMED, JUDGE, DONE.
REQ-010 IDLE: start -> FETCH; start clears last_combo, now_cnt, last_base_score and rom_addr to 0.
REQ-011 FETCH: assert rom_rd for exactly one cycle -> WAIT.
REQ-012 WAIT: latch rom_data into goal_*; end_flag=1 -> DONE without judging; otherwise -> ARMED.
REQ-013 ARMED, hit_valid=1: latch play_time=song_time and play_* = hit fields -> JUDGE.
REQ-014 ARMED, no hit, song_time > goal_time+MISS_WIN (CLK_W+1-bit compare, no wrap): set play_time=song_time and play_note=~goal_note -> JUDGE with the miss flag set.
REQ-015 ARMED, hit_valid and expiry in the same cycle: the hit wins and the note is not a miss.
REQ-016 JUDGE lasts one cycle, with judge_valid=1 and judge_miss equal to the miss flag; play_* and goal_* are held stable.
REQ-017 At the end of the JUDGE cycle, last_base_score SHALL be updated to last_base_score+base_score_in, saturating at 2^21-1.
REQ-018 At the end of the JUDGE cycle, last_combo SHALL be updated to miss ? 0 : combo_in.
REQ-019 At the end of the JUDGE cycle, now_cnt SHALL be incremented by 1, saturating at 2^21-1.
REQ-020 After the JUDGE cycle: if rom_addr equals 2^ADDR_W-1 -> DONE; otherwise rom_addr+1 -> FETCH.
REQ-021 SHALL ignore hit_valid in IDLE, FETCH, WAIT, JUDGE and DONE, with no counter change.
REQ-022 DONE: done=1 and held until start; start -> same action as from IDLE.
REQ-023 busy SHALL be 1 in FETCH, WAIT, ARMED and JUDGE.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort in any busy state -> IDLE next cycle, with no judge_valid and counters retained.
REQ-026 abort in the same cycle as JUDGE: the accumulation still commits, then -> IDLE.
REQ-027 Chart entries SHALL be judged in ROM order; at most one judgement per entry.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE.
REQ-029 rst_n=0 SHALL immediately force every output to 0, including rom_rd, judge_valid, done and busy.
REQ-030 rst_n=0 SHALL immediately clear all counters and goal_*/play_* registers.
REQ-031 Reset mid-playback SHALL discard the in-flight note; no judge_valid after release until a new start.

Verification
REQ-032 Chart {t=100,n=3},{end}; start; hit n=3 at song_time 105 -> one judge_valid with judge_miss=0, play_time=105; base_score_in=1000 -> last_base_score=1000, now_cnt=1; then done=1.
REQ-033 Same chart, no hit -> judge_valid at the first cycle with song_time=289, judge_miss=1, play_note=4; last_combo=0, now_cnt=1.
REQ-034 hit_valid in the exact cycle song_time becomes 289 -> judge_miss=0; play_time=289.
REQ-035 last_base_score=2^21-10 and base_score_in=100 -> last_base_score=2^21-1.
REQ-036 abort while ARMED -> IDLE, busy=0, no judge_valid; a following start clears the counters and refetches address 0.
REQ-037 rst_n pulse while in JUDGE -> all outputs 0 asynchronously; the counters do not commit.
